// File: rtl/mcpu_alu_pkg.sv
// Shared constants for the MCPU ALU arbiter: opcodes, FSM states and requester IDs.
package mcpu_alu_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/mcpu_alu_arbiter_alu.sv
// MCPU_Alu: combinational AND/OR/XOR/ADD unit.
// OVERFLOW flags signed overflow on ADD only.
module MCPU_Alu
    import mcpu_alu_pkg::*;
#(
    parameter int CMD_SIZE  = 2,
    parameter int WORD_SIZE = 8
) (
    input  logic [CMD_SIZE-1:0]  opcode,
    input  logic [WORD_SIZE-1:0] r1,
    input  logic [WORD_SIZE-1:0] r2,
    output logic [WORD_SIZE-1:0] out,
    output logic                 OVERFLOW
);

    logic [WORD_SIZE-1:0] w_sum;

    assign w_sum = r1 + r2;

    always_comb begin
        out      = '0;
        OVERFLOW = 1'b0;
        case (opcode)
            CMD_SIZE'(OP_AND): out = r1 & r2;
            CMD_SIZE'(OP_OR):  out = r1 | r2;
            CMD_SIZE'(OP_XOR): out = r1 ^ r2;
            CMD_SIZE'(OP_ADD): begin
                out = w_sum;
                // Same-sign operands producing an opposite-sign sum.
                OVERFLOW = (r1[WORD_SIZE-1] == r2[WORD_SIZE-1]) &&
                           (w_sum[WORD_SIZE-1] != r1[WORD_SIZE-1]);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mcpu_alu_arbiter.sv
// Round-robin arbiter sharing one MCPU_Alu between requesters A and B.
// Optional MCPU_ALU_ARB_STATS_EN adds saturating ops/overflow counters.
module mcpu_alu_arbiter
    import mcpu_alu_pkg::*;
#(
    parameter int CMD_SIZE  = 2,
    parameter int WORD_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_req_valid,
    output logic                 a_req_ready,
    input  logic [CMD_SIZE-1:0]  a_opcode,
    input  logic [WORD_SIZE-1:0] a_r1,
    input  logic [WORD_SIZE-1:0] a_r2,
    output logic                 a_resp_valid,
    input  logic                 a_resp_ready,
    input  logic                 b_req_valid,
    output logic                 b_req_ready,
    input  logic [CMD_SIZE-1:0]  b_opcode,
    input  logic [WORD_SIZE-1:0] b_r1,
    input  logic [WORD_SIZE-1:0] b_r2,
    output logic                 b_resp_valid,
    input  logic                 b_resp_ready,
`ifdef MCPU_ALU_ARB_STATS_EN
    output logic [15:0]          ops_count,
    output logic [15:0]          ovf_count,
`endif
    output logic [WORD_SIZE-1:0] resp_out,
    output logic                 resp_overflow
);

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_last;
    logic                 r_owner;
    logic [CMD_SIZE-1:0]  r_opcode;
    logic [WORD_SIZE-1:0] r_r1;
    logic [WORD_SIZE-1:0] r_r2;
    logic [WORD_SIZE-1:0] r_resp_out;
    logic                 r_resp_ovf;
    logic                 w_grant;
    logic                 w_accept;
    logic                 w_consume;
    logic [WORD_SIZE-1:0] w_alu_out;
    logic                 w_alu_ovf;

    MCPU_Alu #(
        .CMD_SIZE  (CMD_SIZE),
        .WORD_SIZE (WORD_SIZE)
    ) u_alu (
        .opcode   (r_opcode),
        .r1       (r_r1),
        .r2       (r_r2),
        .out      (w_alu_out),
        .OVERFLOW (w_alu_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_consume    = 1'b0;
        a_req_ready  = 1'b0;
        b_req_ready  = 1'b0;
        a_resp_valid = 1'b0;
        b_resp_valid = 1'b0;
        if (a_req_valid && b_req_valid) w_grant = ~r_last;
        else if (b_req_valid)           w_grant = REQ_B;
        else                            w_grant = REQ_A;
        case (r_state)
            ST_IDLE: begin
                // Ready is forced low while reset is held so no handshake is visible.
                a_req_ready = rst_n && a_req_valid && (w_grant == REQ_A);
                b_req_ready = rst_n && b_req_valid && (w_grant == REQ_B);
                if (a_req_valid || b_req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: w_state_next = ST_RESP;
            ST_RESP: begin
                a_resp_valid = (r_owner == REQ_A);
                b_resp_valid = (r_owner == REQ_B);
                w_consume    = (r_owner == REQ_A) ? a_resp_ready : b_resp_ready;
                if (w_consume) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last     <= REQ_B;
            r_owner    <= REQ_A;
            r_opcode   <= '0;
            r_r1       <= '0;
            r_r2       <= '0;
            r_resp_out <= '0;
            r_resp_ovf <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner  <= w_grant;
                r_opcode <= (w_grant == REQ_B) ? b_opcode : a_opcode;
                r_r1     <= (w_grant == REQ_B) ? b_r1 : a_r1;
                r_r2     <= (w_grant == REQ_B) ? b_r2 : a_r2;
            end
            if (r_state == ST_EXEC) begin
                r_resp_out <= w_alu_out;
                r_resp_ovf <= w_alu_ovf;
            end
            if (w_consume) r_last <= r_owner;
        end
    end

    assign resp_out      = r_resp_out;
    assign resp_overflow = r_resp_ovf;

`ifdef MCPU_ALU_ARB_STATS_EN
    logic [15:0] r_ops_count;
    logic [15:0] r_ovf_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ops_count <= '0;
            r_ovf_count <= '0;
        end else if (w_consume) begin
            if (r_ops_count != 16'hFFFF)                r_ops_count <= r_ops_count + 16'd1;
            if (r_resp_ovf && r_ovf_count != 16'hFFFF)  r_ovf_count <= r_ovf_count + 16'd1;
        end
    end

    assign ops_count = r_ops_count;
    assign ovf_count = r_ovf_count;
`endif

endmodule

// File: tb/tb_mcpu_alu_arbiter.sv
// Scoreboard bench for mcpu_alu_arbiter: directed requests push expected
// responses; a negedge monitor pops and compares on every response consume.
module tb_mcpu_alu_arbiter;
    import mcpu_alu_pkg::*;

    typedef struct packed {
        logic       who;
        logic [7:0] res;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_req_valid = 1'b0, b_req_valid = 1'b0;
    logic       a_req_ready, b_req_ready;
    logic [1:0] a_opcode = '0, b_opcode = '0;
    logic [7:0] a_r1 = '0, a_r2 = '0, b_r1 = '0, b_r2 = '0;
    logic       a_resp_valid, b_resp_valid;
    logic       a_resp_ready = 1'b1, b_resp_ready = 1'b1;
    logic [7:0] resp_out;
    logic       resp_overflow;
`ifdef MCPU_ALU_ARB_STATS_EN
    logic [15:0] ops_count, ovf_count;
    logic [15:0] ops_before, ovf_before;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic grant_log[$];
    int   waited;

    always #5 clk = ~clk;

    mcpu_alu_arbiter #(.CMD_SIZE(2), .WORD_SIZE(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_req_valid  (a_req_valid),
        .a_req_ready  (a_req_ready),
        .a_opcode     (a_opcode),
        .a_r1         (a_r1),
        .a_r2         (a_r2),
        .a_resp_valid (a_resp_valid),
        .a_resp_ready (a_resp_ready),
        .b_req_valid  (b_req_valid),
        .b_req_ready  (b_req_ready),
        .b_opcode     (b_opcode),
        .b_r1         (b_r1),
        .b_r2         (b_r2),
        .b_resp_valid (b_resp_valid),
        .b_resp_ready (b_resp_ready),
`ifdef MCPU_ALU_ARB_STATS_EN
        .ops_count    (ops_count),
        .ovf_count    (ovf_count),
`endif
        .resp_out     (resp_out),
        .resp_overflow(resp_overflow)
    );

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Monitor: one line per consumed response, compared against the scoreboard head.
    always @(negedge clk) begin
        if (a_resp_valid && b_resp_valid) begin
            checks++; errors++;
            $display("FAIL resp_both_valid got=11 want=one-hot");
        end
        if ((a_resp_valid && a_resp_ready) || (b_resp_valid && b_resp_ready)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected owner=%0d res=%h ovf=%0d want=none",
                         b_resp_valid, resp_out, resp_overflow);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (b_resp_valid !== e.who || resp_out !== e.res || resp_overflow !== e.ovf) begin
                    errors++;
                    $display("FAIL resp got owner=%0d res=%h ovf=%0d want owner=%0d res=%h ovf=%0d",
                             b_resp_valid, resp_out, resp_overflow, e.who, e.res, e.ovf);
                end else begin
                    $display("resp owner=%0d res=%h ovf=%0d ok", e.who, e.res, e.ovf);
                end
            end
        end
    end

    // Present a request and hold it until the arbiter grants it (bounded).
    task automatic do_req(input logic who, input logic [1:0] op, input logic [7:0] r1,
                          input logic [7:0] r2, input logic [7:0] er, input logic eo,
                          output int n);
        bit got = 0;
        if (who == REQ_A) begin a_req_valid = 1; a_opcode = op; a_r1 = r1; a_r2 = r2; end
        else              begin b_req_valid = 1; b_opcode = op; b_r1 = r1; b_r2 = r2; end
        n = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if ((who == REQ_A) ? a_req_ready : b_req_ready) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL req_grant who=%0d got=no-ready want=ready", who);
        end else begin
            exp_q.push_back('{who: who, res: er, ovf: eo});
            grant_log.push_back(who);
        end
        @(posedge clk); #1;
        if (who == REQ_A) a_req_valid = 0; else b_req_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin @(posedge clk); n++; end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst_n = 0;
        #1;
        check("rst_resp_out", {8'h0, resp_out}, 16'h0);
        check("rst_ovf", {15'h0, resp_overflow}, 16'h0);
        check("rst_valids", {12'h0, a_req_ready, b_req_ready, a_resp_valid, b_resp_valid}, 16'h0);
        @(negedge clk); #2;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic check_grants(input string name, input logic [5:0] want, input int cnt);
        logic [5:0] got = '0;
        for (int i = 0; i < cnt; i++) got[i] = (grant_log.size() > 0) ? grant_log.pop_front() : 1'bx;
        check(name, {10'h0, got}, {10'h0, want});
    endtask

    initial begin
        // Reset state.
        #1;
        check("init_resp_out", {8'h0, resp_out}, 16'h0);
        check("init_valids", {12'h0, a_req_ready, b_req_ready, a_resp_valid, b_resp_valid}, 16'h0);
        #20 rst_n = 1;
        @(posedge clk); #1;

        // A only: ADD 05+03, latency check.
        do_req(REQ_A, OP_ADD, 8'h05, 8'h03, 8'h08, 1'b0, waited);
        check("a_only_ready_first_cycle", 16'(waited), 16'd1);
        @(posedge clk); #1;
        check("a_only_resp_valid", {14'h0, a_resp_valid, b_resp_valid}, 16'b10);
        check("a_only_resp_out", {8'h0, resp_out}, 16'h08);
        drain();
        grant_log.delete();

        // Tie after reset: A wins first.
        do_reset();
        fork
            do_req(REQ_A, OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, waited);
            begin int w; do_req(REQ_B, OP_XOR, 8'hF0, 8'h3C, 8'hCC, 1'b0, w); end
        join
        drain();
        check_grants("tie_order", 6'b000010, 2);

        // Fairness: both held for 3 ops each; bit i = grant i.
        fork
            begin int w;
                do_req(REQ_A, OP_OR,  8'h0F, 8'hF0, 8'hFF, 1'b0, w);
                do_req(REQ_A, OP_ADD, 8'h10, 8'h20, 8'h30, 1'b0, w);
                do_req(REQ_A, OP_AND, 8'hAA, 8'h0F, 8'h0A, 1'b0, w);
            end
            begin int w;
                do_req(REQ_B, OP_XOR, 8'hAA, 8'h55, 8'hFF, 1'b0, w);
                do_req(REQ_B, OP_ADD, 8'h80, 8'h80, 8'h00, 1'b1, w);
                do_req(REQ_B, OP_OR,  8'h00, 8'h00, 8'h00, 1'b0, w);
            end
        join
        drain();
        check_grants("fair_order", 6'b101010, 6);

        // Backpressure on A while B waits.
        a_resp_ready = 0;
        do_req(REQ_A, OP_ADD, 8'h12, 8'h34, 8'h46, 1'b0, waited);
        b_req_valid = 1; b_opcode = OP_AND; b_r1 = 8'hFF; b_r2 = 8'h0F;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check("bp_b_req_ready", {15'h0, b_req_ready}, 16'h0);
            if (k >= 2) check("bp_a_hold", {7'h0, a_resp_valid, resp_out}, {8'h01, 8'h46});
        end
        @(posedge clk); #1;
        a_resp_ready = 1;
        do_req(REQ_B, OP_AND, 8'hFF, 8'h0F, 8'h0F, 1'b0, waited);
        check("bp_b_grant_after_consume", 16'(waited), 16'd2);
        drain();
        grant_log.delete();

        // Reset mid-EXEC: op is dropped, outputs clear immediately.
        a_req_valid = 1; a_opcode = OP_ADD; a_r1 = 8'h01; a_r2 = 8'h01;
        @(negedge clk);
        check("midrst_grant", {15'h0, a_req_ready}, 16'h1);
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        check("midrst_resp_out", {7'h0, resp_overflow, resp_out}, 16'h0);
        check("midrst_valids", {12'h0, a_req_ready, b_req_ready, a_resp_valid, b_resp_valid}, 16'h0);
        a_req_valid = 0;
        @(negedge clk); #2;
        rst_n = 1;
        repeat (6) @(posedge clk);
        #1;

        // Overflow on the next A request.
`ifdef MCPU_ALU_ARB_STATS_EN
        ops_before = ops_count; ovf_before = ovf_count;
`endif
        do_req(REQ_A, OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b1, waited);
        drain();
        do_req(REQ_A, OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b0, waited);
        drain();
`ifdef MCPU_ALU_ARB_STATS_EN
        check("stats_ops", ops_count, ops_before + 16'd2);
        check("stats_ovf", ovf_count, ovf_before + 16'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
